// File: rtl/svm_pkg.sv
// Shared definitions for the SVM decision datapath: default widths and
// the accumulate/saturate FSM state encoding.
package svm_pkg;

    // Q16.16 product width.
    localparam int DATA_W = 32;
    // 255 full-scale products plus bias stay within a 40-bit signed range.
    localparam int ACC_W  = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2
    } state_t;

endpackage

// File: rtl/svm_dot_accum_if.sv
// Request/stream/result bundle between the upstream multiplier stage
// (master) and the dot-product accumulator (slave).
interface svm_dot_accum_if #(
    parameter int DATA_W = svm_pkg::DATA_W
);
    logic                     start;
    logic signed [DATA_W-1:0] bias;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     busy;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_class;
    logic                     out_sat;

    modport master (
        output start, bias, in_valid, in_data,
        input  busy, out_valid, out_data, out_class, out_sat
    );

    modport slave (
        input  start, bias, in_valid, in_data,
        output busy, out_valid, out_data, out_class, out_sat
    );
endinterface

// File: rtl/svm_sat_clip.sv
// Combinational clip of the wide accumulator to the signed DATA_W range,
// flagging when the value had to be clamped.
module svm_sat_clip
    import svm_pkg::*;
#(
    parameter int DATA_W = svm_pkg::DATA_W,
    parameter int ACC_W  = svm_pkg::ACC_W
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] data,
    output logic                     sat
);

    // Returns {sat, clipped value}. The value fits when every bit from the
    // DATA_W sign bit upward is a copy of the same sign.
    function automatic logic [DATA_W:0] clip(input logic signed [ACC_W-1:0] a);
        logic [ACC_W-DATA_W:0] head;
        logic [DATA_W:0]       r;
        head = a[ACC_W-1:DATA_W-1];
        if ((&head) || !(|head)) begin
            r = {1'b0, a[DATA_W-1:0]};
        end else if (a[ACC_W-1]) begin
            r = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            r = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
        end
        return r;
    endfunction

    // Pure combinational clip of the current accumulator.
    always_comb begin
        {sat, data} = clip(acc);
    end

endmodule

// File: rtl/svm_dot_accum.sv
// SVM decision accumulator: sums VEC_LEN signed products onto a bias in a
// wide accumulator, then saturates to DATA_W and reports the sign decision.
module svm_dot_accum
    import svm_pkg::*;
#(
    parameter int VEC_LEN = 16,
    parameter int DATA_W  = svm_pkg::DATA_W,
    parameter int ACC_W   = svm_pkg::ACC_W
) (
    input  logic           clk,
    input  logic           rst_n,
    svm_dot_accum_if.slave bus
);

    localparam int             CNT_W    = 8;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         cnt;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  data_ext;
    logic signed [DATA_W-1:0] clip_data;
    logic                     clip_sat;

    assign bias_ext = {{(ACC_W-DATA_W){bus.bias[DATA_W-1]}}, bus.bias};
    assign data_ext = {{(ACC_W-DATA_W){bus.in_data[DATA_W-1]}}, bus.in_data};

    svm_sat_clip #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_sat_clip (
        .acc  (acc),
        .data (clip_data),
        .sat  (clip_sat)
    );

    // Control FSM plus accumulator and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_class <= 1'b0;
            bus.out_sat   <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Any in_valid seen here belongs to no transaction.
                    if (bus.start) begin
                        acc      <= bias_ext;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= ACCUM;
                    end else begin
                        bus.busy <= 1'b0;
                    end
                end
                ACCUM: begin
                    // start is ignored until the current result is out.
                    if (bus.in_valid) begin
                        acc <= acc + data_ext;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_IDX) begin
                            state <= SAT;
                        end
                    end
                end
                SAT: begin
                    bus.out_data  <= clip_data;
                    bus.out_class <= ~clip_data[DATA_W-1];
                    bus.out_sat   <= clip_sat;
                    bus.out_valid <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_svm_dot_accum.sv
// Bench for svm_dot_accum with VEC_LEN=4: directed vector table, random
// transactions against an integer-arithmetic model, and hand-written
// reset / back-to-back sequences.
module tb_svm_dot_accum;

    localparam int VL = 4;

    typedef struct packed {
        logic [31:0]      bias;
        logic [3:0][31:0] p;
        logic [7:0]       gap;
        logic [31:0]      exp_data;
        logic             exp_class;
        logic             exp_sat;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    svm_dot_accum_if #(.DATA_W(32)) bus();

    svm_dot_accum #(
        .VEC_LEN (VL),
        .DATA_W  (32),
        .ACC_W   (40)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no summary, expected completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] b, input logic [31:0] p0, input logic [31:0] p1,
                                input logic [31:0] p2, input logic [31:0] p3, input logic [7:0] gap,
                                input logic [31:0] d, input logic c, input logic s);
        vec_t v;
        v.bias = b;
        v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
        v.gap = gap;
        v.exp_data = d; v.exp_class = c; v.exp_sat = s;
        return v;
    endfunction

    // Reference: exact integer sum, then clamp to the 32-bit signed range.
    function automatic void model(input logic [31:0] b, input logic [3:0][31:0] p,
                                  output logic [31:0] d, output logic c, output logic s);
        longint sum;
        int     t;
        t = int'(b);
        sum = longint'(t);
        for (int i = 0; i < VL; i++) begin
            t = int'(p[i]);
            sum += longint'(t);
        end
        c = (sum >= 0);
        if (sum > longint'(32'h7FFFFFFF)) begin
            d = 32'h7FFFFFFF; s = 1'b1;
        end else if (sum < -longint'(32'h80000000)) begin
            d = 32'h80000000; s = 1'b1;
        end else begin
            d = sum[31:0]; s = 1'b0;
        end
    endfunction

    function automatic logic [31:0] rnd_val();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 2))
            0: return r;
            1: return {{12{r[31]}}, r[19:0]};
            default: return r[31] ? (32'h80000000 + {12'd0, r[19:0]})
                                  : (32'h7FFFFFFF - {12'd0, r[19:0]});
        endcase
    endfunction

    task automatic do_start(input logic [31:0] b, input bit junk_valid);
        bus.start    = 1'b1;
        bus.bias     = b;
        bus.in_valid = junk_valid;
        bus.in_data  = $urandom;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.bias     = $urandom;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic feed(input logic [3:0][31:0] p, input logic [7:0] gap, input bit restart_mid);
        for (int i = 0; i < VL; i++) begin
            for (int g = 0; g < int'(gap[2*i +: 2]); g++) begin
                bus.in_valid = 1'b0;
                bus.in_data  = $urandom;
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = p[i];
            if (restart_mid && i == 2) begin
                bus.start = 1'b1;
                bus.bias  = $urandom;
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
    endtask

    task automatic expect_result(input string nm, input logic [31:0] d, input logic c, input logic s,
                                 input bit chain, input logic [31:0] nb);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'd1);
        chk({nm, "_data"}, bus.out_data, d);
        chk({nm, "_class"}, 32'(bus.out_class), 32'(c));
        chk({nm, "_sat"}, 32'(bus.out_sat), 32'(s));
        chk({nm, "_busy_at_valid"}, 32'(bus.busy), 32'd1);
        if (chain) begin
            bus.start = 1'b1;
            bus.bias  = nb;
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk({nm, "_valid_width"}, 32'(bus.out_valid), 32'd0);
        chk({nm, "_busy_after"}, 32'(bus.busy), chain ? 32'd1 : 32'd0);
        chk({nm, "_hold"}, bus.out_data, d);
    endtask

    initial begin
        vec_t             tbl[12];
        logic [31:0]      rd;
        logic             rc;
        logic             rs;
        logic [31:0]      rb;
        logic [3:0][31:0] rp;
        logic [7:0]       rg;
        logic [3:0][31:0] pz;

        bus.start = 1'b0; bus.bias = '0; bus.in_valid = 1'b0; bus.in_data = '0;

        tbl[0]  = mk(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 8'h00, 32'h00050000, 1'b1, 1'b0);
        tbl[1]  = mk(32'h00000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 8'h00, 32'h7FFFFFFF, 1'b1, 1'b1);
        tbl[2]  = mk(32'h00000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 8'h00, 32'h80000000, 1'b0, 1'b1);
        tbl[3]  = mk(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 8'h48, 32'h00050000, 1'b1, 1'b0);
        tbl[4]  = mk(32'hFFFF0000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 8'h00, 32'hFFFF0000, 1'b0, 1'b0);
        tbl[5]  = mk(32'h7FFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 32'h00000000, 8'h00, 32'h7FFFFFFF, 1'b1, 1'b1);
        tbl[6]  = mk(32'h7FFFFFFE, 32'h00000001, 32'h00000000, 32'h00000000, 32'h00000000, 8'h00, 32'h7FFFFFFF, 1'b1, 1'b0);
        tbl[7]  = mk(32'h80000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 8'h00, 32'h80000000, 1'b0, 1'b0);
        tbl[8]  = mk(32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000, 8'h00, 32'h80000000, 1'b0, 1'b1);
        tbl[9]  = mk(32'h00000000, 32'h00000005, 32'hFFFFFFFB, 32'h00000000, 32'h00000000, 8'h11, 32'h00000000, 1'b1, 1'b0);
        tbl[10] = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h00000000, 8'h00, 32'hFFFFFFFE, 1'b0, 1'b0);
        tbl[11] = mk(32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000001, 8'h40, 32'h00000000, 1'b1, 1'b0);

        // Reset state.
        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_class", 32'(bus.out_class), 32'd0);
        chk("rst_out_sat", 32'(bus.out_sat), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Samples without a start must not produce anything.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_data = $urandom;
            @(negedge clk);
            chk("idle_no_valid", 32'(bus.out_valid), 32'd0);
            chk("idle_no_busy", 32'(bus.busy), 32'd0);
        end
        bus.in_valid = 1'b0;

        // Directed table; odd entries also present a sample alongside start.
        for (int k = 0; k < 12; k++) begin
            do_start(tbl[k].bias, k[0]);
            feed(tbl[k].p, tbl[k].gap, k == 3);
            expect_result($sformatf("tbl%0d", k), tbl[k].exp_data, tbl[k].exp_class, tbl[k].exp_sat, 1'b0, 32'd0);
        end

        // Back-to-back: start accepted in the out_valid cycle.
        pz[0] = 32'h00010000; pz[1] = 32'h00010000; pz[2] = 32'h00010000; pz[3] = 32'h00010000;
        do_start(32'h00010000, 1'b0);
        feed(pz, 8'h00, 1'b0);
        expect_result("chain_a", 32'h00050000, 1'b1, 1'b0, 1'b1, 32'h00000100);
        pz[0] = 32'h1; pz[1] = 32'h1; pz[2] = 32'h1; pz[3] = 32'h1;
        feed(pz, 8'h00, 1'b0);
        expect_result("chain_b", 32'h00000104, 1'b1, 1'b0, 1'b0, 32'd0);

        // Reset after two of four samples.
        do_start(32'h00030000, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h00010000;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_out_data", bus.out_data, 32'd0);
        chk("midrst_out_class", 32'(bus.out_class), 32'd0);
        chk("midrst_out_sat", 32'(bus.out_sat), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = $urandom;
            @(negedge clk);
            chk("postrst_no_valid", 32'(bus.out_valid), 32'd0);
            chk("postrst_no_busy", 32'(bus.busy), 32'd0);
        end
        bus.in_valid = 1'b0;
        pz = '0;
        do_start(32'hFFFF0000, 1'b0);
        feed(pz, 8'h00, 1'b0);
        expect_result("postrst_run", 32'hFFFF0000, 1'b0, 1'b0, 1'b0, 32'd0);

        // Random transactions against the reference model.
        for (int k = 0; k < 40; k++) begin
            rb = rnd_val();
            for (int i = 0; i < VL; i++) rp[i] = rnd_val();
            rg = 8'($urandom) & 8'h55;
            model(rb, rp, rd, rc, rs);
            do_start(rb, 1'($urandom_range(0, 1)));
            feed(rp, rg, 1'($urandom_range(0, 1)));
            expect_result($sformatf("rnd%0d", k), rd, rc, rs, 1'b0, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
